// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: 2-flop RX synchroniser, mid-bit sampling FSM, show-ahead RX FIFO, sticky flags.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (adds oPARITY_ERR).
module uart_rx_frame_ctrl #(
    parameter int CLOCK_PERIOD      = 10_000_000,
    parameter int BAUD_RATE         = 115_200,
    parameter int BAUD_PERIOD_COUNT = CLOCK_PERIOD / BAUD_RATE,
    parameter int HALF_PERIOD_COUNT = BAUD_PERIOD_COUNT / 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int PARITY_ODD        = 0
) (
    input  logic                          iCLK,
    input  logic                          iRESETn,
    input  logic                          iUART_RX,
    input  logic                          iRX_EN,
    input  logic                          iRD_POP,
    input  logic                          iERR_CLR,
    output logic [7:0]                    oRX_DATA,
    output logic                          oRX_VALID,
    output logic                          oRX_FULL,
    output logic [$clog2(FIFO_DEPTH):0]   oRX_LEVEL,
    output logic                          oRX_BUSY,
    output logic                          oFRAME_ERR,
    output logic                          oOVERRUN
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          oPARITY_ERR
`endif
);

    localparam int CNT_W = $clog2(BAUD_PERIOD_COUNT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PERIOD_COUNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD_COUNT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               sample_tick, stop_tick, push, push_ok, pop_ok;
`ifdef UART_RX_PARITY_EN
    logic               parity_err_q, parity_err_d;
    logic               parity_set;
`endif

    // State register, datapath and FIFO pointers
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= iUART_RX;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // FIFO storage is not reset; the head is masked while empty
    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s_q) state_d = START;
            START:  if (cnt_q == HALF_LAST) state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (cnt_q == BAUD_LAST && bit_cnt_q == 3'd7) state_d = PARITY;
`else
            DATA:   if (cnt_q == BAUD_LAST && bit_cnt_q == 3'd7) state_d = STOP;
`endif
            PARITY: if (cnt_q == BAUD_LAST) state_d = STOP;
            STOP:   if (cnt_q == BAUD_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!iRX_EN) state_d = IDLE;
    end

    // Output / datapath logic
    always_comb begin
        sample_tick = (cnt_q == BAUD_LAST);
        if (state_q == IDLE || state_d != state_q || (state_q == DATA && sample_tick)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        bit_cnt_d = (state_q == IDLE) ? 3'd0 : bit_cnt_q;
        shift_d   = shift_q;
        if (iRX_EN && state_q == DATA && sample_tick) begin
            shift_d[bit_cnt_q] = rx_s_q;
            bit_cnt_d          = bit_cnt_q + 1'b1;
        end

        stop_tick = iRX_EN && state_q == STOP && sample_tick;
        push      = stop_tick && rx_s_q;

        // Pop is applied before push, so a full FIFO can accept a byte on a pop cycle
        pop_ok   = iRD_POP && (level_q != '0);
        push_ok  = push && ((level_q != LVL_FULL) || pop_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

        frame_err_d = (stop_tick && !rx_s_q) ? 1'b1 : (iERR_CLR ? 1'b0 : frame_err_q);
        overrun_d   = (push && !push_ok)     ? 1'b1 : (iERR_CLR ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
        parity_set   = iRX_EN && state_q == PARITY && sample_tick &&
                       ((^shift_q ^ rx_s_q) != 1'(PARITY_ODD));
        parity_err_d = parity_set ? 1'b1 : (iERR_CLR ? 1'b0 : parity_err_q);
`endif
    end

    assign oRX_VALID  = (level_q != '0);
    assign oRX_FULL   = (level_q == LVL_FULL);
    assign oRX_LEVEL  = level_q;
    assign oRX_DATA   = oRX_VALID ? mem_q[rd_ptr_q] : 8'h00;
    assign oRX_BUSY   = (state_q != IDLE);
    assign oFRAME_ERR = frame_err_q;
    assign oOVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign oPARITY_ERR = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random frames against a queue-based receiver model.
// Honours UART_RX_PARITY_EN (adds the parity bit and oPARITY_ERR checks).
module tb_uart_rx_frame_ctrl;
    localparam int BAUD  = 86;
    localparam int DEPTH = 4;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edge of the push relative to the launch of the start bit (sync + START entry + sampling)
    localparam int PUSH_AT = 3 + BAUD / 2 + (NBITS - 1) * BAUD;

    logic       iCLK = 1'b0, iRESETn = 1'b0, iUART_RX = 1'b1;
    logic       iRX_EN = 1'b0, iRD_POP = 1'b0, iERR_CLR = 1'b0;
    logic [7:0] oRX_DATA;
    logic       oRX_VALID, oRX_FULL, oRX_BUSY, oFRAME_ERR, oOVERRUN;
    logic [2:0] oRX_LEVEL;
`ifdef UART_RX_PARITY_EN
    logic       oPARITY_ERR;
`endif

    uart_rx_frame_ctrl dut (
        .iCLK(iCLK), .iRESETn(iRESETn), .iUART_RX(iUART_RX), .iRX_EN(iRX_EN),
        .iRD_POP(iRD_POP), .iERR_CLR(iERR_CLR), .oRX_DATA(oRX_DATA), .oRX_VALID(oRX_VALID),
        .oRX_FULL(oRX_FULL), .oRX_LEVEL(oRX_LEVEL), .oRX_BUSY(oRX_BUSY),
        .oFRAME_ERR(oFRAME_ERR), .oOVERRUN(oOVERRUN)
`ifdef UART_RX_PARITY_EN
        , .oPARITY_ERR(oPARITY_ERR)
`endif
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] mq [$];
    bit m_frame = 0, m_ovr = 0, m_par = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        iUART_RX = v;
        tick(BAUD);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ PAR_ODD ^ par_bad);
`endif
        drive_bit(stop_bit);
        iUART_RX = 1'b1;
    endtask

    // Reference receiver: what a completed frame does to the queue and flags
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
`ifdef UART_RX_PARITY_EN
        if (!par_ok) m_par = 1;
`endif
        if (!stop_ok) m_frame = 1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"},  32'(oRX_DATA),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, "_valid"}, 32'(oRX_VALID),  32'(mq.size() != 0));
        chk({tag, "_level"}, 32'(oRX_LEVEL),  32'(mq.size()));
        chk({tag, "_full"},  32'(oRX_FULL),   32'(mq.size() == DEPTH));
        chk({tag, "_ferr"},  32'(oFRAME_ERR), 32'(m_frame));
        chk({tag, "_ovr"},   32'(oOVERRUN),   32'(m_ovr));
`ifdef UART_RX_PARITY_EN
        chk({tag, "_perr"},  32'(oPARITY_ERR), 32'(m_par));
`endif
    endtask

    task automatic frame_txn(input logic [7:0] b, input logic stop_bit, input logic par_bad);
        send_frame(b, stop_bit, par_bad);
        model_frame(b, stop_bit, !par_bad);
        tick(100);
        $display("frame 0x%02h stop=%0d pbad=%0d -> level=%0d ferr=%0d ovr=%0d",
                 b, stop_bit, par_bad, oRX_LEVEL, oFRAME_ERR, oOVERRUN);
    endtask

    task automatic pop_txn();
        iRD_POP = 1'b1;
        tick(1);
        iRD_POP = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        $display("pop -> level=%0d head=0x%02h", oRX_LEVEL, oRX_DATA);
    endtask

    task automatic clr_txn();
        iERR_CLR = 1'b1;
        tick(1);
        iERR_CLR = 1'b0;
        m_frame = 0; m_ovr = 0; m_par = 0;
        $display("err_clr -> ferr=%0d ovr=%0d", oFRAME_ERR, oOVERRUN);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_data", 32'(oRX_DATA), 0);
        chk("rst_valid", 32'(oRX_VALID), 0);
        chk("rst_level", 32'(oRX_LEVEL), 0);
        chk("rst_busy", 32'(oRX_BUSY), 0);
        chk("rst_flags", {29'd0, oFRAME_ERR, oOVERRUN, oRX_FULL}, 0);
        iRESETn = 1'b1;
        iRX_EN  = 1'b1;
        tick(5);

        // Single good frame
        frame_txn(8'hA5, 1'b1, 1'b0);
        check_all("t1");
        chk("t1_a5", 32'(oRX_DATA), 32'h A5);
        pop_txn();
        check_all("t1_pop");

        // Short low glitch on the line
        iUART_RX = 1'b0;
        tick(20);
        iUART_RX = 1'b1;
        tick(3);
        chk("t2_busy_start", 32'(oRX_BUSY), 1);
        tick(100);
        chk("t2_busy_idle", 32'(oRX_BUSY), 0);
        check_all("t2");

        // Framing error then clear
        frame_txn(8'h3C, 1'b0, 1'b0);
        check_all("t3");
        chk("t3_ferr_set", 32'(oFRAME_ERR), 1);
        clr_txn();
        chk("t3_ferr_clr", 32'(oFRAME_ERR), 0);

        // Overrun with no pops
        for (int v = 1; v <= 5; v++) frame_txn(8'(v), 1'b1, 1'b0);
        check_all("t4");
        chk("t4_full", 32'(oRX_FULL), 1);
        chk("t4_head", 32'(oRX_DATA), 32'h01);
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", 32'(oRX_DATA), 32'(i + 1));
            pop_txn();
        end
        chk("t4_empty", 32'(oRX_VALID), 0);
        clr_txn();

        // Pop on the exact push cycle of a full FIFO
        for (int v = 8'h11; v <= 8'h14; v++) frame_txn(8'(v), 1'b1, 1'b0);
        check_all("t5_pre");
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                repeat (PUSH_AT - 1) @(posedge iCLK);
                #1 iRD_POP = 1'b1;
                @(posedge iCLK);
                #1 iRD_POP = 1'b0;
            end
        join
        void'(mq.pop_front());
        model_frame(8'h77, 1'b1, 1'b1);
        tick(100);
        $display("frame 0x77 with pop on push cycle -> level=%0d ovr=%0d", oRX_LEVEL, oOVERRUN);
        check_all("t5");
        chk("t5_ovr", 32'(oOVERRUN), 0);
        for (int i = 0; i < 3; i++) pop_txn();
        chk("t5_last", 32'(oRX_DATA), 32'h77);
        pop_txn();
        check_all("t5_drain");

        // Receiver disabled mid-frame
        fork
            send_frame(8'hC3, 1'b1, 1'b0);
            begin
                tick(BAUD * 4 + 40);
                iRX_EN = 1'b0;
                tick(2);
                chk("t6_dis_busy", 32'(oRX_BUSY), 0);
            end
        join
        iRX_EN = 1'b1;
        tick(100);
        frame_txn(8'h5A, 1'b1, 1'b0);
        check_all("t6a");
        chk("t6a_5a", 32'(oRX_DATA), 32'h5A);
        pop_txn();

        // Reset mid-frame wipes FIFO and flags
        frame_txn(8'h42, 1'b1, 1'b0);
        frame_txn(8'h99, 1'b0, 1'b0);
        check_all("t6b_pre");
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                tick(BAUD * 3);
                iRESETn = 1'b0;
                #2;
                chk("t6b_rst_busy", 32'(oRX_BUSY), 0);
                chk("t6b_rst_level", 32'(oRX_LEVEL), 0);
            end
        join
        mq.delete();
        m_frame = 0; m_ovr = 0; m_par = 0;
        iRESETn = 1'b1;
        tick(5);
        check_all("t6b_post");
        frame_txn(8'h5A, 1'b1, 1'b0);
        check_all("t6b");
        pop_txn();

`ifdef UART_RX_PARITY_EN
        frame_txn(8'h5A, 1'b1, 1'b1);
        check_all("t6p");
        chk("t6p_perr", 32'(oPARITY_ERR), 1);
        pop_txn();
        clr_txn();
`endif

        // Randomised frames, pops and clears
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic       stop_bit, pbad;
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            pbad     = ($urandom_range(0, 5) == 0);
`else
            pbad     = 1'b0;
`endif
            frame_txn(b, stop_bit, pbad);
            check_all("rnd_frame");
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_txn();
            if ($urandom_range(0, 3) == 0) clr_txn();
            check_all("rnd_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
